// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard beside the ID stage: stalls ID until every source
// operand is readable or forwardable, and keeps younger writes from overtaking older ones.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned LAT_W       = 3,
  parameter int unsigned NOFWD_LAT   = 2,
  parameter int unsigned LD_FWD_LAT  = 1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   forward_EN,
  input  logic                   id_valid,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      src1_ID,
  input  logic [ADDR_W-1:0]      src2_ID,
  input  logic                   src2_used,
  input  logic [ADDR_W-1:0]      dest_ID,
  input  logic                   WB_EN_ID,
  input  logic                   MEM_R_EN_ID,
  input  logic [LAT_W-1:0]       extra_lat,
  output logic                   hazard_detected,
  output logic [NUM_REGS-1:0]    pending_mask,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int unsigned MAX_LAT = (2 ** LAT_W) - 1;

  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [31:0]      lat_base;
  logic [31:0]      lat_sum;
  logic [LAT_W-1:0] lat;
  logic             raw;
  logic             waw;
  logic             issue;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    lat_base = 32'(NOFWD_LAT);
    if (forward_EN) begin
      lat_base = MEM_R_EN_ID ? 32'(LD_FWD_LAT) : 32'd0;
    end
    lat_sum = lat_base + 32'(extra_lat);
    lat     = (lat_sum > 32'(MAX_LAT)) ? LAT_W'(MAX_LAT) : lat_sum[LAT_W-1:0];
  end

  always_comb begin
    raw = ((src1_ID != '0) && (cnt[src1_ID] != '0)) ||
          (src2_used && (src2_ID != '0) && (cnt[src2_ID] != '0));
    // Strictly greater: an equal remaining count retires the older write first.
    waw = WB_EN_ID && (dest_ID != '0) && (cnt[dest_ID] > lat);
    hazard_detected = id_valid && !flush && (raw || waw);
    issue           = id_valid && !flush && !hazard_detected;
  end

  always_comb begin
    pending_mask = '0;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      pending_mask[r] = (cnt[r] != '0);
    end
  end

  // NOTE: the counter array is a bank of flops, not a RAM, and it must be
  // cleared on reset so no phantom in-flight writes survive a pipeline reset.
  // NOTE: sequential state uses non-blocking assignments so every counter
  // updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 1; r < int'(NUM_REGS); r++) begin
        if (issue && WB_EN_ID && (dest_ID == ADDR_W'(r))) begin
          cnt[r] <= lat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end
      cnt[0] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (hazard_detected && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard: one row per cycle, expected values queued on
// drive and popped at the falling edge; hand sequences cover reset and stall saturation.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        forward_EN;
  logic        id_valid;
  logic        flush;
  logic [4:0]  src1_ID;
  logic [4:0]  src2_ID;
  logic        src2_used;
  logic [4:0]  dest_ID;
  logic        WB_EN_ID;
  logic        MEM_R_EN_ID;
  logic [2:0]  extra_lat;
  logic        hazard_detected;
  logic [31:0] pending_mask;
  logic [15:0] stall_cycles;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .forward_EN(forward_EN), .id_valid(id_valid), .flush(flush),
    .src1_ID(src1_ID), .src2_ID(src2_ID), .src2_used(src2_used), .dest_ID(dest_ID),
    .WB_EN_ID(WB_EN_ID), .MEM_R_EN_ID(MEM_R_EN_ID), .extra_lat(extra_lat),
    .hazard_detected(hazard_detected), .pending_mask(pending_mask), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fwd, vld, fl;
    logic [4:0]  s1, s2;
    logic        s2u;
    logic [4:0]  dst;
    logic        wb, ld;
    logic [2:0]  xl;
    logic        haz;
    logic [31:0] mask;
  } vec_t;

  typedef struct {
    logic        haz;
    logic [31:0] mask;
    logic [15:0] stalls;
  } exp_t;

  localparam int NROWS = 33;
  vec_t tbl [NROWS];
  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;
  int   stall_model = 0;

  function automatic vec_t mk(logic fwd, logic vld, logic fl, logic [4:0] s1, logic [4:0] s2,
                              logic s2u, logic [4:0] dst, logic wb, logic ld, logic [2:0] xl,
                              logic haz, logic [31:0] mask);
    vec_t v;
    v.fwd = fwd; v.vld = vld; v.fl = fl; v.s1 = s1; v.s2 = s2; v.s2u = s2u;
    v.dst = dst; v.wb = wb; v.ld = ld; v.xl = xl; v.haz = haz; v.mask = mask;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    forward_EN = v.fwd; id_valid = v.vld; flush = v.fl;
    src1_ID = v.s1; src2_ID = v.s2; src2_used = v.s2u;
    dest_ID = v.dst; WB_EN_ID = v.wb; MEM_R_EN_ID = v.ld; extra_lat = v.xl;
  endtask

  task automatic apply_row(input int idx);
    exp_t e;
    exp_t got;
    @(posedge clk);
    #1;
    drive(tbl[idx]);
    e.haz    = tbl[idx].haz;
    e.mask   = tbl[idx].mask;
    e.stalls = 16'(stall_model);
    sb.push_back(e);
    if (tbl[idx].haz) stall_model++;
    @(negedge clk);
    got = sb.pop_front();
    check($sformatf("row%0d hazard", idx), 32'(hazard_detected), 32'(got.haz));
    check($sformatf("row%0d pending_mask", idx), pending_mask, got.mask);
    check($sformatf("row%0d stall_cycles", idx), 32'(stall_cycles), 32'(got.stalls));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                fwd vld fl s1  s2 s2u dst wb ld xl  haz mask
    tbl[0]  = mk(0, 1, 0, 1,  2, 1, 3,  1, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 1, 0, 3,  0, 0, 4,  1, 0, 0, 1, 32'h8);
    tbl[2]  = mk(0, 1, 0, 3,  0, 0, 4,  1, 0, 0, 1, 32'h8);
    tbl[3]  = mk(0, 1, 0, 3,  0, 0, 4,  1, 0, 0, 0, 32'h0);
    tbl[4]  = mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 32'h10);
    tbl[5]  = mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 32'h10);
    tbl[6]  = mk(1, 1, 0, 0,  0, 0, 5,  1, 1, 0, 0, 32'h0);
    tbl[7]  = mk(1, 1, 0, 0,  5, 1, 6,  1, 0, 0, 1, 32'h20);
    tbl[8]  = mk(1, 1, 0, 0,  5, 1, 6,  1, 0, 0, 0, 32'h0);
    tbl[9]  = mk(1, 1, 0, 0,  0, 0, 5,  1, 1, 0, 0, 32'h0);
    tbl[10] = mk(1, 1, 0, 0,  5, 0, 6,  1, 0, 0, 0, 32'h20);
    tbl[11] = mk(1, 1, 0, 0,  0, 0, 7,  1, 0, 4, 0, 32'h0);
    tbl[12] = mk(1, 1, 0, 0,  0, 0, 7,  1, 0, 0, 1, 32'h80);
    tbl[13] = mk(1, 1, 0, 0,  0, 0, 7,  1, 0, 0, 1, 32'h80);
    tbl[14] = mk(1, 1, 0, 0,  0, 0, 7,  1, 0, 0, 1, 32'h80);
    tbl[15] = mk(1, 1, 0, 0,  0, 0, 7,  1, 0, 0, 1, 32'h80);
    tbl[16] = mk(1, 1, 0, 0,  0, 0, 7,  1, 0, 0, 0, 32'h0);
    tbl[17] = mk(1, 1, 0, 0,  0, 0, 8,  1, 0, 2, 0, 32'h0);
    tbl[18] = mk(1, 1, 0, 0,  0, 0, 8,  1, 0, 1, 1, 32'h100);
    tbl[19] = mk(1, 1, 0, 0,  0, 0, 8,  1, 0, 1, 0, 32'h100);
    tbl[20] = mk(1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 32'h100);
    tbl[21] = mk(1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 32'h0);
    tbl[22] = mk(0, 1, 0, 0,  0, 0, 0,  1, 0, 0, 0, 32'h0);
    tbl[23] = mk(0, 1, 0, 0,  0, 1, 0,  1, 0, 0, 0, 32'h0);
    tbl[24] = mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 32'h0);
    tbl[25] = mk(0, 1, 0, 0,  0, 0, 9,  1, 0, 0, 0, 32'h0);
    tbl[26] = mk(0, 1, 1, 9,  0, 0, 10, 1, 0, 0, 0, 32'h200);
    tbl[27] = mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 32'h200);
    tbl[28] = mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 32'h0);
    tbl[29] = mk(0, 1, 0, 0,  0, 0, 11, 1, 0, 7, 0, 32'h0);
    tbl[30] = mk(0, 1, 0, 0,  0, 0, 11, 1, 0, 6, 0, 32'h800);
    tbl[31] = mk(0, 1, 0, 11, 0, 0, 0,  0, 0, 0, 1, 32'h800);
    tbl[32] = mk(0, 1, 0, 0,  0, 0, 3,  1, 0, 0, 0, 32'h800);

    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset hazard", 32'(hazard_detected), 32'h0);
    check("reset pending_mask", pending_mask, 32'h0);
    check("reset stall_cycles", 32'(stall_cycles), 32'h0);

    for (int i = 0; i < NROWS; i++) apply_row(i);

    // Mid-operation reset with cnt[3]=2 and cnt[11] still counting.
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(mk(0, 1, 0, 3, 11, 1, 0, 0, 0, 0, 0, 32'h0));
    @(negedge clk);
    check("midreset hazard", 32'(hazard_detected), 32'h0);
    check("midreset pending_mask", pending_mask, 32'h0);
    check("midreset stall_cycles", 32'(stall_cycles), 32'h0);

    // Self-dependent lat=7 op: issues once per 8 cycles, stalls the other 7.
    @(posedge clk);
    #1;
    drive(mk(1, 1, 0, 3, 0, 0, 3, 1, 0, 7, 0, 32'h0));
    for (int c = 0; c <= 74904; c++) begin
      @(negedge clk);
      if (c == 1) check("sat first stall hazard", 32'(hazard_detected), 32'h1);
      if (c == 1) check("sat first stall mask", pending_mask, 32'h8);
      if (c == 8) check("sat reissue hazard", 32'(hazard_detected), 32'h0);
      if (c == 74896) check("stall_cycles pre-sat", 32'(stall_cycles), 32'd65534);
      if (c == 74904) check("stall_cycles saturated", 32'(stall_cycles), 32'h0000FFFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
